mac_ram_sequencer: RTL and testbench

Sequences the shared 32×16 dual-port `ram` for the MAC datapath and computes a signed dot product over its contents. On `start`, it reads operand vector A through port A and vector B through port B, one element pair per cycle. It multiply-accumulates the pairs, then writes the saturated 32-bit result back through both ports in a single cycle. While idle, it grants port A to a host interface for preload and readback, so the RAM has exactly one owner at any time.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/mac_sat32.sv | 33 +++
 rtl/mac_ram_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mac_ram_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC RAM sequencer and its datapath helpers.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int ACC_W  = 40;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } mac_state_e;

  // 32-bit saturation limits.
  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Clamp a requested element count to the RAM depth (2^aw).
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] req);
    logic [ADDR_W:0] depth;
    depth = {1'b1, {ADDR_W{1'b0}}};
    if (req > depth) begin
      clamp_len = depth;
    end else begin
      clamp_len = req;
    end
  endfunction

endpackage

// File: rtl/mac_sat32.sv
// Combinational saturator: signed ACC_W accumulator to signed 32 bits plus a clamp flag.
module mac_sat32
  import mac_pkg::*;
#(
  parameter int ACC_W = mac_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [31:0]      val_o,
  output logic             sat_o
);

  logic neg_s;
  logic hi_any_s;
  logic hi_all_s;

  // Value fits in 32 bits only if bits [ACC_W-1:31] are all copies of the sign.
  always_comb begin
    neg_s    = acc_i[ACC_W-1];
    hi_any_s = |acc_i[ACC_W-2:31];
    hi_all_s = &acc_i[ACC_W-2:31];
    if (!neg_s && hi_any_s) begin
      val_o = SAT_MAX;
      sat_o = 1'b1;
    end else if (neg_s && !hi_all_s) begin
      val_o = SAT_MIN;
      sat_o = 1'b1;
    end else begin
      val_o = acc_i[31:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/mac_ram_sequencer.sv
// Owns the shared dual-port RAM: host access while idle, dot-product reads
// and a saturated two-word result write while busy.
module mac_ram_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ADDR_W = mac_pkg::ADDR_W,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              sat,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_dout,
  output logic              ram_we_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_a,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_a,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam int PROD_W = 2 * DATA_W;

  mac_state_e        state_q,  state_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W:0]   len_q,    len_d;
  logic [ADDR_W-1:0] dst_q,    dst_d;
  logic [ADDR_W-1:0] idx_q,    idx_d;
  logic              vld_q,    vld_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [31:0]       result_q, result_d;
  logic              sat_q,    sat_d;

  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]         prod_ext_s;
  logic [ADDR_W:0]          len_clamp_s;
  logic                     last_s;
  logic [31:0]              sat_val_s;
  logic                     sat_flag_s;

  // Saturation of the finished accumulator; acc_q is stable throughout WRITE.
  mac_sat32 #(.ACC_W(ACC_W)) u_sat (
    .acc_i (acc_q),
    .val_o (sat_val_s),
    .sat_o (sat_flag_s)
  );

  // Signed product of the pair returned by the RAM, sign-extended, plus run bookkeeping.
  always_comb begin
    prod_s      = $signed(ram_dout_a) * $signed(ram_dout_b);
    prod_ext_s  = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    len_clamp_s = clamp_len(len);
    last_s      = ({1'b0, idx_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));
  end

  // Next-state, accumulate and result-capture logic.
  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    dst_d    = dst_q;
    idx_d    = idx_q;
    vld_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    sat_d    = sat_q;

    // vld_q marks a cycle where the RAM outputs hold an issued pair.
    if (vld_q) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = len_clamp_s;
          dst_d    = dst_addr;
          acc_d    = {ACC_W{1'b0}};
          idx_d    = {ADDR_W{1'b0}};
          sat_d    = 1'b0;
          result_d = 32'h0000_0000;
          busy_d   = 1'b1;
          if (len_clamp_s != {(ADDR_W + 1){1'b0}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        vld_d = 1'b1;
        idx_d = idx_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
        if (last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        result_d = sat_val_s;
        sat_d    = sat_flag_s;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port ownership: host on port A while idle, sequencer otherwise.
  always_comb begin
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    ram_addr_a = {ADDR_W{1'b0}};
    ram_addr_b = {ADDR_W{1'b0}};
    ram_din_a  = {DATA_W{1'b0}};
    ram_din_b  = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        ram_we_a   = host_we;
        ram_addr_a = host_addr;
        ram_din_a  = host_din;
      end
      ST_RUN: begin
        ram_addr_a = base_a_q + idx_q;
        ram_addr_b = base_b_q + idx_q;
      end
      ST_DRAIN: begin
        ram_we_a = 1'b0;
        ram_we_b = 1'b0;
      end
      ST_WRITE: begin
        ram_we_a   = 1'b1;
        ram_addr_a = dst_q;
        ram_din_a  = sat_val_s[DATA_W-1:0];
        ram_we_b   = 1'b1;
        ram_addr_b = dst_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
        ram_din_b  = sat_val_s[2*DATA_W-1:DATA_W];
      end
      default: begin
        ram_we_a = 1'b0;
        ram_we_b = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_a_q <= {ADDR_W{1'b0}};
      base_b_q <= {ADDR_W{1'b0}};
      len_q    <= {(ADDR_W + 1){1'b0}};
      dst_q    <= {ADDR_W{1'b0}};
      idx_q    <= {ADDR_W{1'b0}};
      vld_q    <= 1'b0;
      acc_q    <= {ACC_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0000_0000;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      dst_q    <= dst_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign sat        = sat_q;
  assign host_ready = ~busy_q;
  assign host_dout  = ram_dout_a;

endmodule

// File: tb/tb_mac_ram_sequencer.sv
// Scoreboard bench for mac_ram_sequencer with a behavioural 32x16 dual-port RAM.
module tb_mac_ram_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_a = 5'd0;
  logic [4:0]  base_b = 5'd0;
  logic [5:0]  len = 6'd0;
  logic [4:0]  dst_addr = 5'd0;
  logic        busy, done, sat, host_ready;
  logic [31:0] result;
  logic        host_we = 1'b0;
  logic [4:0]  host_addr = 5'd0;
  logic [15:0] host_din = 16'd0;
  logic [15:0] host_dout;
  logic        ram_we_a, ram_we_b;
  logic [4:0]  ram_addr_a, ram_addr_b;
  logic [15:0] ram_din_a, ram_din_b;
  logic [15:0] ram_dout_a, ram_dout_b;

  logic [15:0] mem [32];

  typedef struct {
    logic [31:0] res;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t        dq[$];
  logic [15:0] rdq[$];
  logic        rd_req = 1'b0;
  logic        rd_req_q = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mac_ram_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b), .len(len), .dst_addr(dst_addr),
    .busy(busy), .done(done), .result(result), .sat(sat),
    .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_ready(host_ready), .host_dout(host_dout),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // Synchronous-read dual-port RAM model.
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
    rd_req_q   <= rd_req;
    cyc        <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse and host readback against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (dq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = dq.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("sat", {63'd0, sat}, {63'd0, e.sat});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
    if (rd_req_q) begin
      if (rdq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL readback_queue: got empty queue expected an entry");
      end else begin
        check("readback", {48'd0, host_dout}, {48'd0, rdq.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_din = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, input logic [15:0] exp);
    host_addr = a; rd_req = 1'b1;
    rdq.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic start_op(input logic [4:0] ba, input logic [4:0] bb, input logic [5:0] l,
                          input logic [4:0] d, input logic [31:0] res, input logic s, input int lat);
    exp_t e;
    base_a = ba; base_b = bb; len = l; dst_addr = d; start = 1'b1;
    tick();
    start = 1'b0;
    e.res = res; e.sat = s; e.cyc = cyc + lat;
    dq.push_back(e);
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 200 && dq.size() != 0; i++) tick();
    check("done_timeout_pending", 64'(dq.size()), 64'd0);
    dq.delete();
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_sat", {63'd0, sat}, 64'd0);
    check("rst_host_ready", {63'd0, host_ready}, 64'd1);
    check("rst_we_b", {63'd0, ram_we_b}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic dot product: 5*3 + 15*23 + 25*43 + 35*63 = 3640.
    host_write(5'd0, 16'd5);  host_write(5'd1, 16'd15);
    host_write(5'd2, 16'd25); host_write(5'd3, 16'd35);
    host_write(5'd8, 16'd3);  host_write(5'd9, 16'd23);
    host_write(5'd10, 16'd43); host_write(5'd11, 16'd63);
    start_op(5'd0, 5'd8, 6'd4, 5'd16, 32'd3640, 1'b0, 6);
    wait_done();
    host_read(5'd16, 16'h0E38); host_read(5'd17, 16'h0000);

    // Signed: -2*3 + 7*-4 = -34.
    host_write(5'd12, 16'hFFFE); host_write(5'd13, 16'd7);
    host_write(5'd14, 16'd3);    host_write(5'd15, 16'hFFFC);
    start_op(5'd12, 5'd14, 6'd2, 5'd20, 32'hFFFF_FFDE, 1'b0, 4);
    wait_done();
    host_read(5'd20, 16'hFFDE); host_read(5'd21, 16'hFFFF);

    // Wrap-around: A at 30,31,0,1 = 100,-200,5,15; B = 3,23,43,63 -> -3140.
    host_write(5'd30, 16'd100); host_write(5'd31, 16'hFF38);
    start_op(5'd30, 5'd8, 6'd4, 5'd31, 32'hFFFF_F3BC, 1'b0, 6);
    check("wrap_addr0", {59'd0, ram_addr_a}, 64'd30);
    tick();
    check("wrap_addr1", {59'd0, ram_addr_a}, 64'd31);
    tick();
    check("wrap_addr2", {59'd0, ram_addr_a}, 64'd0);
    tick();
    check("wrap_addr3", {59'd0, ram_addr_a}, 64'd1);
    wait_done();
    host_read(5'd31, 16'hF3BC); host_read(5'd0, 16'hFFFF); host_read(5'd1, 16'd15);

    // Positive saturation with len 40 clamped to 32: 32 * 2^30.
    for (int i = 0; i < 32; i++) host_write(i[4:0], 16'h8000);
    start_op(5'd0, 5'd0, 6'd40, 5'd4, 32'h7FFF_FFFF, 1'b1, 34);
    wait_done();
    host_read(5'd4, 16'hFFFF); host_read(5'd5, 16'h7FFF);

    // Negative saturation: 8 * (-32768 * 32767).
    for (int i = 8; i < 16; i++) host_write(i[4:0], 16'h7FFF);
    start_op(5'd16, 5'd8, 6'd8, 5'd24, 32'h8000_0000, 1'b1, 10);
    wait_done();
    host_read(5'd24, 16'h0000); host_read(5'd25, 16'h8000);

    // len = 0 writes zero after one edge.
    host_write(5'd26, 16'h1234); host_write(5'd27, 16'h5678);
    start_op(5'd3, 5'd3, 6'd0, 5'd26, 32'd0, 1'b0, 1);
    wait_done();
    host_read(5'd26, 16'h0000); host_read(5'd27, 16'h0000);

    // Start and host write during RUN are ignored: 1*5+2*6+3*7+4*8 = 70.
    host_write(5'd0, 16'd1); host_write(5'd1, 16'd2);
    host_write(5'd2, 16'd3); host_write(5'd3, 16'd4);
    host_write(5'd8, 16'd5); host_write(5'd9, 16'd6);
    host_write(5'd10, 16'd7); host_write(5'd11, 16'd8);
    start_op(5'd0, 5'd8, 6'd4, 5'd28, 32'd70, 1'b0, 6);
    tick();
    base_a = 5'd16; start = 1'b1;
    host_we = 1'b1; host_addr = 5'd2; host_din = 16'h0BAD;
    #1;
    check("host_ready_busy", {63'd0, host_ready}, 64'd0);
    check("we_a_busy", {63'd0, ram_we_a}, 64'd0);
    tick();
    start = 1'b0; host_we = 1'b0;
    wait_done();
    host_read(5'd2, 16'd3); host_read(5'd28, 16'd70); host_read(5'd29, 16'd0);

    // Reset during RUN aborts with no write and no done.
    host_write(5'd20, 16'h1111); host_write(5'd21, 16'h2222);
    base_a = 5'd0; base_b = 5'd8; len = 6'd4; dst_addr = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_ready", {63'd0, host_ready}, 64'd1);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    host_read(5'd20, 16'h1111); host_read(5'd21, 16'h2222);

    // A subsequent start completes normally.
    start_op(5'd0, 5'd8, 6'd4, 5'd20, 32'd70, 1'b0, 6);
    wait_done();
    host_read(5'd20, 16'd70); host_read(5'd21, 16'd0);
    repeat (3) tick();
    check("readback_queue_empty", 64'(rdq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
